// File: rtl/core_readout_scheduler.sv
// Round-robin readout scheduler: grants one finished core at a time to the shared
// output scanner, acknowledges it once drained, and aborts stalled streams via a watchdog.
module core_readout_scheduler #(
  parameter int unsigned M_COUNT        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                       clk,
  input  logic                       resetb,
  input  logic                       enable,
  input  logic [M_COUNT-1:0]         core_done,
  input  logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       out_last,
  output logic [M_COUNT-1:0]         access_core,
  output logic [M_COUNT-1:0]         core_ack,
  output logic                       busy,
  output logic                       timeout,
  output logic [$clog2(M_COUNT)-1:0] err_core,
  output logic [CNT_W-1:0]           drained_cnt
);

  localparam int unsigned       CORE_W   = $clog2(M_COUNT);
  localparam int unsigned       WD_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [CORE_W-1:0] LAST_RST = CORE_W'(M_COUNT - 1);
  localparam logic [M_COUNT-1:0] ONE_HOT0 = M_COUNT'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_RELEASE,
    S_COOL
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CORE_W-1:0]   r_grant_idx, w_grant_idx_nxt;
  logic [CORE_W-1:0]   r_last_idx, w_last_idx_nxt;
  logic [CORE_W-1:0]   r_err_core, w_err_core_nxt;
  logic [WD_W-1:0]     r_wd, w_wd_nxt;
  logic [M_COUNT-1:0]  r_access, w_access_nxt;
  logic [M_COUNT-1:0]  r_ack, w_ack_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

  logic                w_beat, w_fin, w_wd_expired;
  logic                w_found;
  logic [CORE_W-1:0]   w_winner;
  logic [31:0]         w_cand;

  assign w_beat       = out_valid & out_ready;
  assign w_fin        = w_beat & out_last;
  assign w_wd_expired = (TIMEOUT_CYCLES != 0) && (r_wd == WD_LIMIT);

  // Search begins one past the previous winner and wraps, so the last-served core ranks lowest.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int unsigned off = 1; off <= M_COUNT; off++) begin
      w_cand = {{(32-CORE_W){1'b0}}, r_last_idx} + off;
      if (w_cand >= M_COUNT) begin
        w_cand = w_cand - M_COUNT;
      end
      if (!w_found && core_done[w_cand[CORE_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[CORE_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_idx_nxt = r_grant_idx;
    w_last_idx_nxt  = r_last_idx;
    w_err_core_nxt  = r_err_core;
    w_wd_nxt        = r_wd;
    w_access_nxt    = r_access;
    w_ack_nxt       = '0;
    w_timeout_nxt   = 1'b0;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_access_nxt = '0;
        if (enable && w_found) begin
          w_grant_idx_nxt = w_winner;
          w_last_idx_nxt  = w_winner;
          w_wd_nxt        = '0;
          w_access_nxt    = ONE_HOT0 << w_winner;
          w_state_nxt     = S_GRANT;
        end
      end
      S_GRANT: begin
        // A final beat takes priority over a watchdog that has just reached its limit.
        if (w_fin) begin
          w_state_nxt  = S_RELEASE;
          w_access_nxt = '0;
          w_ack_nxt    = ONE_HOT0 << r_grant_idx;
          if (r_cnt != '1) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else if (w_wd_expired) begin
          w_state_nxt    = S_RELEASE;
          w_access_nxt   = '0;
          w_ack_nxt      = ONE_HOT0 << r_grant_idx;
          w_timeout_nxt  = 1'b1;
          w_err_core_nxt = r_grant_idx;
        end else if (w_beat) begin
          w_wd_nxt = '0;
        end else if (r_wd != WD_LIMIT) begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      S_RELEASE: begin
        w_access_nxt = '0;
        w_state_nxt  = S_COOL;
      end
      S_COOL: begin
        w_access_nxt = '0;
        w_state_nxt  = S_IDLE;
      end
      default: begin
        w_access_nxt = '0;
        w_state_nxt  = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_grant_idx <= '0;
      r_last_idx  <= LAST_RST;
      r_err_core  <= '0;
      r_wd        <= '0;
      r_access    <= '0;
      r_ack       <= '0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_grant_idx <= w_grant_idx_nxt;
      r_last_idx  <= w_last_idx_nxt;
      r_err_core  <= w_err_core_nxt;
      r_wd        <= w_wd_nxt;
      r_access    <= w_access_nxt;
      r_ack       <= w_ack_nxt;
      r_busy      <= w_busy_nxt;
      r_timeout   <= w_timeout_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign access_core = r_access;
  assign core_ack    = r_ack;
  assign busy        = r_busy;
  assign timeout     = r_timeout;
  assign err_core    = r_err_core;
  assign drained_cnt = r_cnt;

endmodule
